// File: rtl/ssd_pkg.sv
// Shared definitions for the seven-segment display path: converter state
// encoding, the blank-digit code and an elaboration-time power-of-ten helper.
package ssd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } bcd_state_t;

    localparam logic [3:0] BCD_BLANK = 4'hF;

    function automatic logic [63:0] pow10(input int n);
        logic [63:0] r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/bcd_add3.sv
// One double-dabble nibble adjust: digits of 5 or more get +3 before the shift.
module bcd_add3 (
    input  logic [3:0] din,
    output logic [3:0] dout
);

    assign dout = (din >= 4'd5) ? din + 4'd3 : din;

endmodule

// File: rtl/bin_to_bcd.sv
// Sequential binary-to-BCD converter, one input bit per clock. The packed
// digit word only changes on the completion edge, so slower readers see it whole.
module bin_to_bcd
    import ssd_pkg::*;
#(
    parameter int DIGITS = 8,
    parameter int WIDTH  = 27
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic [WIDTH-1:0]      binary,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [4*DIGITS-1:0]   numbers
);

    localparam int             CW    = $clog2(WIDTH + 1);
    localparam logic [WIDTH:0] LIMIT = (WIDTH + 1)'(pow10(DIGITS));

    bcd_state_t                 state, next_state;
    logic [CW-1:0]              cnt;
    logic [WIDTH-1:0]           bin_sr;
    logic [DIGITS-1:0][3:0]     acc, acc_adj;
    logic                       ovf_flag;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bcd_add3 u_add3 (
            .din  (acc[g]),
            .dout (acc_adj[g])
        );
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:  if (start) next_state = ST_SHIFT;
            ST_SHIFT: if (cnt == CW'(1)) next_state = ST_DONE;
            ST_DONE:  next_state = ST_IDLE;
            default:  next_state = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            bin_sr   <= '0;
            acc      <= '0;
            ovf_flag <= 1'b0;
            numbers  <= '0;
            overflow <= 1'b0;
            done     <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state <= next_state;
            done  <= (state == ST_DONE);
            // Held through the completion cycle so busy spans the full WIDTH+2 slot.
            busy  <= (next_state != ST_IDLE) || (state == ST_DONE);
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        bin_sr   <= binary;
                        acc      <= '0;
                        cnt      <= CW'(WIDTH);
                        ovf_flag <= ({1'b0, binary} >= LIMIT);
                    end
                end
                ST_SHIFT: begin
                    {acc, bin_sr} <= {acc_adj, bin_sr} << 1;
                    cnt           <= cnt - CW'(1);
                end
                ST_DONE: begin
                    numbers  <= ovf_flag ? {DIGITS{BCD_BLANK}} : acc;
                    overflow <= ovf_flag;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd.sv
// Randomized bench for bin_to_bcd against a decimal-arithmetic reference.
module tb_bin_to_bcd;

    localparam int DIGITS = 8;
    localparam int WIDTH  = 27;

    logic                 clk;
    logic                 reset;
    logic                 start;
    logic [WIDTH-1:0]     binary;
    logic                 busy, done, overflow;
    logic [4*DIGITS-1:0]  numbers;

    int n_chk  = 0;
    int n_pass = 0;

    bin_to_bcd #(.DIGITS(DIGITS), .WIDTH(WIDTH)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .binary   (binary),
        .busy     (busy),
        .done     (done),
        .overflow (overflow),
        .numbers  (numbers)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got %0h exp %0h", tag, got, exp);
    endtask

    function automatic bit ref_ovf(input int unsigned v);
        return longint'(v) >= 64'd100000000;
    endfunction

    function automatic logic [31:0] ref_bcd(input int unsigned v);
        logic [31:0] r;
        int unsigned x;
        if (ref_ovf(v)) return 32'hFFFF_FFFF;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    // k counts negedges after the accepting edge E0; k=28 is the cycle after E28.
    task automatic run_conv(input int unsigned v, input bit poke);
        int          done_k = -1;
        int          nd = 0, nb = 0;
        logic [31:0] got_n = '0;
        logic        got_o = 1'b0;
        @(negedge clk);
        binary = WIDTH'(v);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        binary = WIDTH'($urandom);
        for (int k = 0; k < 36; k++) begin
            if (k > 0) @(negedge clk);
            if (busy) nb++;
            if (done) begin
                nd++;
                done_k = k;
                got_n  = numbers;
                got_o  = overflow;
            end
            if (poke && k == 5) begin
                start  = 1'b1;
                binary = WIDTH'($urandom);
            end
            if (poke && k == 6) start = 1'b0;
        end
        chk($sformatf("done_cycle(%0d)", v), 64'(done_k), 64'd28);
        chk($sformatf("done_pulses(%0d)", v), 64'(nd), 64'd1);
        chk($sformatf("busy_cycles(%0d)", v), 64'(nb), 64'd29);
        chk($sformatf("numbers(%0d)", v), 64'(got_n), 64'(ref_bcd(v)));
        chk($sformatf("overflow(%0d)", v), 64'(got_o), 64'(ref_ovf(v)));
        chk($sformatf("numbers_held(%0d)", v), 64'(numbers), 64'(ref_bcd(v)));
    endtask

    task automatic back_to_back();
        int          nd = 0;
        int          dk[2] = '{-1, -1};
        logic [31:0] dn[2] = '{32'h0, 32'h0};
        @(negedge clk);
        binary = '0;
        start  = 1'b1;
        @(negedge clk);
        binary = WIDTH'(99999999);
        for (int k = 0; k < 70; k++) begin
            if (k > 0) @(negedge clk);
            if (done) begin
                if (nd < 2) begin
                    dk[nd] = k;
                    dn[nd] = numbers;
                end
                nd++;
                if (nd == 2) start = 1'b0;
            end
        end
        start = 1'b0;
        chk("b2b_count", 64'(nd), 64'd2);
        chk("b2b_first_k", 64'(dk[0]), 64'd28);
        chk("b2b_second_k", 64'(dk[1]), 64'd57);
        chk("b2b_first_val", 64'(dn[0]), 64'(ref_bcd(0)));
        chk("b2b_second_val", 64'(dn[1]), 64'(ref_bcd(99999999)));
    endtask

    task automatic reset_mid();
        @(negedge clk);
        binary = WIDTH'(54321);
        start  = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        repeat (9) @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_mid_busy", 64'(busy), 64'd0);
        chk("rst_mid_done", 64'(done), 64'd0);
        chk("rst_mid_numbers", 64'(numbers), 64'd0);
        chk("rst_mid_overflow", 64'(overflow), 64'd0);
        @(negedge clk);
        reset = 1'b1;
        repeat (40) @(negedge clk);
        chk("rst_after_numbers", 64'(numbers), 64'd0);
        chk("rst_after_busy", 64'(busy), 64'd0);
    endtask

    initial begin
        int ndone;
        int unsigned v;
        reset  = 1'b0;
        start  = 1'b0;
        binary = '0;
        repeat (3) @(negedge clk);
        chk("rst_numbers", 64'(numbers), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_overflow", 64'(overflow), 64'd0);
        reset = 1'b1;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("idle_done_count", 64'(ndone), 64'd0);
        chk("idle_numbers", 64'(numbers), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);

        run_conv(12345678, 1'b0);
        run_conv(100000000, 1'b0);
        run_conv(1304507, 1'b0);
        run_conv(87654321, 1'b1);
        run_conv(99999999, 1'b0);
        run_conv(134217727, 1'b0);
        back_to_back();

        for (int i = 0; i < 12; i++) begin
            if (i % 3 == 0) v = $urandom_range(134217727, 0);
            else v = $urandom_range(99999999, 0);
            run_conv(v, i[0]);
        end

        run_conv(100000000, 1'b0);
        reset_mid();
        run_conv(42, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
